spiflash_rd_seq: RTL and testbench
==================================

# spiflash_rd_seq

Read sequencer that turns 32-bit word read requests from the SoC memory interface into the byte-level command stream consumed by the `spimemio_xfer` SPI byte engine. It issues the command, address, mode, dummy and data transfers in order, and assembles the returned bytes into a word. It keeps chip-select asserted between sequential reads so they stream without re-issuing a command, and releases chip-select by resetting the engine. It sits between the flash memory port of the bus and one `spimemio_xfer` instance.

## Interface
Parameters:
- CMD_SPI, 8'h03, single-lane read opcode
- CMD_QSPI, 8'hEB, quad I/O read opcode
- MODE_BYTE, 8'hFF, quad mode byte; must not enable flash continuous-read mode

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- mem_valid  in  1  read request; held with mem_addr until mem_ready
- mem_addr  in  24  byte address; bits [1:0] must be 0
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  32  read word, little-endian (byte at mem_addr in [7:0])
- cfg_qspi  in  1  0 = single-lane 0x03 read, 1 = quad 0xEB read
- cfg_dummy  in  4  quad dummy clock count, 0..15
- xfer_resetn  out  1  active-low reset to the engine; low releases CS
- din_valid/din_data[7:0]/din_tag[3:0]/din_cont/din_dspi/din_qspi/din_ddr/din_rd  out  engine input channel
- din_ready  in  1  engine accepts the byte when din_valid && din_ready
- dout_valid/dout_data[7:0]/dout_tag[3:0]  in  engine output channel

## Operation
- States: IDLE, CMD, ADDR, MODE, DATA, WAIT, DONE, CSREL.
- Each state drives din_valid=1 and holds its fields until the handshake completes. Then it advances a byte index (idx, 2 bits).
- din_cont=1, din_dspi=0 and din_ddr=0 on every byte.
- Tags: command, address and mode bytes use tag 4'b0000. Data byte i uses tag {2'b10, i[1:0]}. Output bytes with tag[3]=0 are discarded.
- CMD: sends CMD_SPI or CMD_QSPI, single-lane, with rd=0.
- ADDR: sends addr[23:16], then [15:8], then [7:0]. Lanes are quad if cfg_qspi=1, else single. rd=0.
- MODE (quad only): sends MODE_BYTE on quad lanes with rd=0.
- DATA: sends 4 bytes. Quad mode uses din_qspi=1 and din_rd=1, with din_data=cfg_dummy on byte 0 of a fresh command and 0 otherwise. Single mode uses din_rd=0 and din_data=0.
- Data capture: on dout_valid with tag {2'b10,i}, dout_data is written to mem_rdata[8i+7:8i]. Capture of byte 3 moves WAIT to DONE.
- DONE: pulses mem_ready and stores next_addr = addr+4 (24-bit wrap) and cfg_q = cfg_qspi. CS stays low. Returns to IDLE.
- IDLE with mem_valid, when CS is low, mem_addr == next_addr and cfg_qspi == cfg_q: goes straight to DATA (continuation, no command, dummy field 0).
- IDLE with mem_valid on any mismatch while CS is low: goes to CSREL, which holds xfer_resetn=0 for 2 cycles, then CMD.
- IDLE with mem_valid while CS is high (after reset or CSREL): goes to CMD.
- mem_valid dropped before mem_ready: the current data phase completes, mem_ready is suppressed, and the state returns to IDLE.

## Timing
- Reset values: mem_ready=0, mem_rdata=0, din_valid=0, din_data=0, din_tag=0, all din flags 0, xfer_resetn=0, state IDLE, CS marked high.
- xfer_resetn goes to 1 on the first cycle after reset deasserts.
- Reset mid-transaction: state IDLE next cycle, xfer_resetn=0, and the pending request is dropped without mem_ready.
- din_valid asserts in the cycle after the state is entered. One byte is in flight at a time from the engine's point of view; din_ready gating is honoured.
- mem_ready is registered: it rises the cycle after byte 3 is captured and lasts exactly 1 cycle. mem_rdata is stable from then until the next capture.
- A new request in IDLE is sampled in the same cycle as mem_ready falls; there is no back-to-back issue in the mem_ready cycle.
- next_addr at 24'hFFFFFC wraps to 24'h000000. A request to 0 then continues.

## Structure
- Package spiflash_pkg: the state enum, tag constants (TAG_CTRL=4'b0000, TAG_DATA=2'b10 prefix), and opcode defaults.
- Single module. An optional sub-module `spiflash_rd_asm` holds the byte-lane assembly and mem_ready register.

## Test plan
- Single mode, read 0x000100 with flash model bytes 11,22,33,44: stimulus -> din sequence is 03,00,01,00 then 4 data bytes; mem_rdata=0x44332211; exactly one mem_ready.
- Quad mode, cfg_dummy=4, read 0x001000: stimulus -> EB single-lane, 3 quad address bytes, FF, then data with byte 0 din_rd=1 and din_data=4; word matches the model.
- Sequential 0x000100 then 0x000104: stimulus -> second read has no CMD or ADDR bytes, xfer_resetn stays 1, and only 4 din handshakes occur.
- Non-sequential 0x000100 then 0x000200, or a cfg_qspi toggle: stimulus -> xfer_resetn low for exactly 2 cycles, then a full command.
- Reset asserted during ADDR: stimulus -> no mem_ready, and the next request restarts with the full command.
- Wrap case, 0xFFFFFC then 0x000000: stimulus -> continuation with no command; random din_ready stalls do not change the resulting words.

Source files
------------

// File: rtl/spiflash_pkg.sv
// Shared types and constants for the SPI flash read sequencer.
// No logic; state encoding, byte tags and default opcodes only.
package spiflash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        MODE,
        DATA,
        WAIT,
        DONE,
        CSREL
    } state_t;

    localparam logic [3:0] TAG_CTRL      = 4'b0000;
    localparam logic [1:0] TAG_DATA      = 2'b10;

    localparam logic [7:0] CMD_SPI_DEF   = 8'h03;
    localparam logic [7:0] CMD_QSPI_DEF  = 8'hEB;
    localparam logic [7:0] MODE_BYTE_DEF = 8'hFF;

endpackage

// File: rtl/spiflash_rd_asm.sv
// Assembles tagged data bytes from the byte engine into the little-endian read word.
// mem_ready is registered one cycle after byte 3 lands; no backpressure, engine output is never stalled.
module spiflash_rd_asm
    import spiflash_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        dout_valid,
    input  logic [7:0]  dout_data,
    input  logic [3:0]  dout_tag,
    input  logic        ready_en,
    output logic        mem_ready,
    output logic [31:0] mem_rdata
);

    logic data_hit;
    assign data_hit = dout_valid && (dout_tag[3:2] == TAG_DATA);

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_ready <= 1'b0;
            mem_rdata <= 32'h0;
        end else begin
            // Abandoned requests still drain their bytes but never raise mem_ready.
            mem_ready <= data_hit && (dout_tag[1:0] == 2'd3) && ready_en;
            if (data_hit) begin
                mem_rdata[8*dout_tag[1:0] +: 8] <= dout_data;
            end
        end
    end

endmodule

// File: rtl/spiflash_rd_seq.sv
// Converts 32-bit flash read requests into a command/address/mode/data byte stream, streaming sequential reads.
// Latency: one byte per engine handshake, mem_ready one cycle after the last data byte; din_ready stalls hold the current byte.
module spiflash_rd_seq
    import spiflash_pkg::*;
#(
    parameter logic [7:0] CMD_SPI   = CMD_SPI_DEF,
    parameter logic [7:0] CMD_QSPI  = CMD_QSPI_DEF,
    parameter logic [7:0] MODE_BYTE = MODE_BYTE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [23:0] mem_addr,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    input  logic        cfg_qspi,
    input  logic [3:0]  cfg_dummy,
    output logic        xfer_resetn,
    output logic        din_valid,
    output logic [7:0]  din_data,
    output logic [3:0]  din_tag,
    output logic        din_cont,
    output logic        din_dspi,
    output logic        din_qspi,
    output logic        din_ddr,
    output logic        din_rd,
    input  logic        din_ready,
    input  logic        dout_valid,
    input  logic [7:0]  dout_data,
    input  logic [3:0]  dout_tag
);

    state_t      state, state_next;
    logic [1:0]  idx, idx_next;
    logic [23:0] addr, next_addr;
    logic        cur_q, cfg_q;
    logic        cs_active, fresh, abort, csrel_cnt, xfer_rst_q;
    logic        hs, last_cap, seq_hit;

    assign hs       = din_valid && din_ready;
    assign last_cap = dout_valid && (dout_tag == {TAG_DATA, 2'b11});
    assign seq_hit  = (mem_addr == next_addr) && (cfg_qspi == cfg_q);

    assign xfer_resetn = xfer_rst_q && (state != CSREL);

    always_comb begin
        state_next = state;
        din_valid  = 1'b0;
        din_data   = 8'h00;
        din_tag    = TAG_CTRL;
        din_cont   = 1'b0;
        din_dspi   = 1'b0;
        din_qspi   = 1'b0;
        din_ddr    = 1'b0;
        din_rd     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_valid) begin
                    if (!cs_active)   state_next = CMD;
                    else if (seq_hit) state_next = DATA;
                    else              state_next = CSREL;
                end
            end
            CMD: begin
                din_valid = 1'b1;
                din_cont  = 1'b1;
                din_data  = cur_q ? CMD_QSPI : CMD_SPI;
                if (hs) state_next = ADDR;
            end
            ADDR: begin
                din_valid = 1'b1;
                din_cont  = 1'b1;
                din_qspi  = cur_q;
                case (idx)
                    2'd0:    din_data = addr[23:16];
                    2'd1:    din_data = addr[15:8];
                    default: din_data = addr[7:0];
                endcase
                if (hs && idx == 2'd2) state_next = cur_q ? MODE : DATA;
            end
            MODE: begin
                din_valid = 1'b1;
                din_cont  = 1'b1;
                din_qspi  = 1'b1;
                din_data  = MODE_BYTE;
                if (hs) state_next = DATA;
            end
            DATA: begin
                din_valid = 1'b1;
                din_cont  = 1'b1;
                din_tag   = {TAG_DATA, idx};
                din_qspi  = cur_q;
                din_rd    = cur_q;
                // Dummy clocks are only owed after a freshly issued quad command.
                if (cur_q && fresh && idx == 2'd0) din_data = {4'h0, cfg_dummy};
                if (hs && idx == 2'd3) state_next = WAIT;
            end
            WAIT:    if (last_cap) state_next = DONE;
            DONE:    state_next = IDLE;
            CSREL:   if (csrel_cnt) state_next = CMD;
            default: state_next = IDLE;
        endcase
        idx_next = idx;
        if (state_next != state) idx_next = 2'd0;
        else if (hs)             idx_next = idx + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= 2'd0;
            addr       <= 24'h0;
            next_addr  <= 24'h0;
            cur_q      <= 1'b0;
            cfg_q      <= 1'b0;
            cs_active  <= 1'b0;
            fresh      <= 1'b0;
            abort      <= 1'b0;
            csrel_cnt  <= 1'b0;
            xfer_rst_q <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            xfer_rst_q <= 1'b1;
            csrel_cnt  <= (state == CSREL) ? ~csrel_cnt : 1'b0;
            if (state == IDLE && mem_valid) begin
                addr  <= mem_addr;
                cur_q <= cfg_qspi;
                abort <= 1'b0;
            end else if (state != IDLE && state != DONE && !mem_valid) begin
                abort <= 1'b1;
            end
            if (state_next == CMD) begin
                cs_active <= 1'b1;
                fresh     <= 1'b1;
            end else if (state == CSREL) begin
                cs_active <= 1'b0;
            end else if (state == IDLE && state_next == DATA) begin
                fresh <= 1'b0;
            end
            // The flash keeps streaming from here, so track it even for abandoned requests.
            if (state == DONE) begin
                next_addr <= addr + 24'd4;
                cfg_q     <= cur_q;
            end
        end
    end

    spiflash_rd_asm u_asm (
        .clk        (clk),
        .reset      (reset),
        .dout_valid (dout_valid),
        .dout_data  (dout_data),
        .dout_tag   (dout_tag),
        .ready_en   ((state == WAIT) && mem_valid && !abort),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

endmodule

// File: tb/tb_spiflash_rd_seq.sv
// Directed bench: behavioural byte engine with a pattern flash, checks byte stream, CS release and read words.
module tb_spiflash_rd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic [23:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        cfg_qspi;
    logic [3:0]  cfg_dummy;
    logic        xfer_resetn;
    logic        din_valid, din_cont, din_dspi, din_qspi, din_ddr, din_rd;
    logic [7:0]  din_data;
    logic [3:0]  din_tag;
    logic        din_ready = 1'b0;
    logic        dout_valid = 1'b0;
    logic [7:0]  dout_data = 8'h00;
    logic [3:0]  dout_tag = 4'h0;

    always #5 clk = ~clk;

    spiflash_rd_seq dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .cfg_qspi(cfg_qspi),
        .cfg_dummy(cfg_dummy), .xfer_resetn(xfer_resetn), .din_valid(din_valid),
        .din_data(din_data), .din_tag(din_tag), .din_cont(din_cont),
        .din_dspi(din_dspi), .din_qspi(din_qspi), .din_ddr(din_ddr),
        .din_rd(din_rd), .din_ready(din_ready), .dout_valid(dout_valid),
        .dout_data(dout_data), .dout_tag(dout_tag)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pattern flash: offsets 0..3 of a word give 11,22,33,44, perturbed by upper address bits.
    function automatic logic [7:0] fbyte(input logic [23:0] a);
        logic [7:0] base;
        base = ({6'b0, a[1:0]} + 8'd1) * 8'h11;
        return base ^ a[23:16] ^ {a[7:2], 2'b00};
    endfunction

    logic [7:0]  lg_dat[$];
    logic [3:0]  lg_tag[$];
    logic        lg_q[$];
    logic        lg_rd[$];
    int          rst_low = 0;
    int          rdy_cnt = 0;
    logic [31:0] last_word = 32'h0;
    logic        stall_en = 1'b0;

    function automatic logic [31:0] ld(input int i);
        return (i < lg_dat.size()) ? {24'h0, lg_dat[i]} : 32'hDEAD;
    endfunction
    function automatic logic [31:0] lt(input int i);
        return (i < lg_tag.size()) ? {28'h0, lg_tag[i]} : 32'hDEAD;
    endfunction
    function automatic logic [31:0] lq(input int i);
        return (i < lg_q.size()) ? {31'h0, lg_q[i]} : 32'hDEAD;
    endfunction
    function automatic logic [31:0] lr(input int i);
        return (i < lg_rd.size()) ? {31'h0, lg_rd[i]} : 32'hDEAD;
    endfunction

    // Byte engine model: one byte in flight, data bytes answered from the flash pattern.
    initial begin
        int          busy = 0;
        int          nctl = 0;
        logic        ret_pend = 1'b0;
        logic [7:0]  ret_dat = 8'h0;
        logic [3:0]  ret_tag = 4'h0;
        logic [23:0] ptr = 24'h0;
        logic [23:0] abuf = 24'h0;
        forever begin
            @(negedge clk);
            if (!xfer_resetn) rst_low++;
            if (mem_ready) begin
                rdy_cnt++;
                last_word = mem_rdata;
            end
            if (din_valid && din_ready && xfer_resetn) begin
                lg_dat.push_back(din_data);
                lg_tag.push_back(din_tag);
                lg_q.push_back(din_qspi);
                lg_rd.push_back(din_rd);
                busy = 3;
                if (din_tag[3]) begin
                    ret_pend = 1'b1;
                    ret_tag  = din_tag;
                    ret_dat  = fbyte(ptr);
                    ptr      = ptr + 24'd1;
                end else begin
                    if (nctl >= 1 && nctl <= 3) abuf = {abuf[15:0], din_data};
                    if (nctl == 3) ptr = {abuf[23:8], din_data};
                    nctl++;
                end
            end
            @(posedge clk);
            #1;
            dout_valid = 1'b0;
            if (!xfer_resetn) begin
                nctl = 0; busy = 0; ret_pend = 1'b0; din_ready = 1'b0;
            end else if (busy > 0) begin
                busy--;
                din_ready = 1'b0;
                if (busy == 0 && ret_pend) begin
                    dout_valid = 1'b1;
                    dout_tag   = ret_tag;
                    dout_data  = ret_dat;
                    ret_pend   = 1'b0;
                end
            end else begin
                din_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    task automatic do_read(input logic [23:0] a, input logic q, output int base,
                           output int hs_n, output int rl_n, output logic [31:0] w);
        int r0, c0, cyc;
        @(posedge clk); #1;
        base = lg_dat.size(); r0 = rst_low; c0 = rdy_cnt; cyc = 0;
        mem_addr = a; cfg_qspi = q; mem_valid = 1'b1;
        while (rdy_cnt == c0 && cyc < 600) begin
            @(posedge clk);
            cyc++;
        end
        #1 mem_valid = 1'b0;
        repeat (4) @(posedge clk);
        chk("ready_pulses", rdy_cnt - c0, 1);
        hs_n = lg_dat.size() - base;
        rl_n = rst_low - r0;
        w    = last_word;
    endtask

    initial begin
        int          b, hs, rl, cyc, c0;
        logic [31:0] w;
        reset = 1'b1; mem_valid = 1'b0; mem_addr = 24'h0; cfg_qspi = 1'b0; cfg_dummy = 4'd4;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", mem_ready, 0);
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_din_valid", din_valid, 0);
        chk("rst_din_flags", {din_data, din_tag, din_cont, din_dspi, din_qspi, din_ddr, din_rd}, 0);
        chk("rst_xfer_resetn", xfer_resetn, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("xfer_resetn_up", xfer_resetn, 1);

        do_read(24'h000100, 1'b0, b, hs, rl, w);
        chk("spi_hs", hs, 8);
        chk("spi_cmd", ld(b), 8'h03);
        chk("spi_a2", ld(b + 1), 8'h00);
        chk("spi_a1", ld(b + 2), 8'h01);
        chk("spi_a0", ld(b + 3), 8'h00);
        chk("spi_tag0", lt(b + 4), 4'h8);
        chk("spi_tag3", lt(b + 7), 4'hB);
        chk("spi_lanes", lq(b + 2), 0);
        chk("spi_word", w, 32'h44332211);

        do_read(24'h000104, 1'b0, b, hs, rl, w);
        chk("seq_hs", hs, 4);
        chk("seq_rst", rl, 0);
        chk("seq_tag", lt(b), 4'h8);
        chk("seq_word", w, 32'h40372615);

        do_read(24'h000200, 1'b0, b, hs, rl, w);
        chk("jump_rst", rl, 2);
        chk("jump_hs", hs, 8);
        chk("jump_cmd", ld(b), 8'h03);
        chk("jump_a1", ld(b + 2), 8'h02);
        chk("jump_word", w, 32'h44332211);

        do_read(24'h001000, 1'b1, b, hs, rl, w);
        chk("quad_rst", rl, 2);
        chk("quad_hs", hs, 9);
        chk("quad_cmd", ld(b), 8'hEB);
        chk("quad_cmd_lane", lq(b), 0);
        chk("quad_addr_lane", lq(b + 1), 1);
        chk("quad_a1", ld(b + 2), 8'h10);
        chk("quad_mode", ld(b + 4), 8'hFF);
        chk("quad_dummy", ld(b + 5), 8'h04);
        chk("quad_rd", lr(b + 5), 1);
        chk("quad_d1", ld(b + 6), 8'h00);
        chk("quad_word", w, 32'h44332211);

        do_read(24'h001004, 1'b1, b, hs, rl, w);
        chk("qseq_hs", hs, 4);
        chk("qseq_nodummy", ld(b), 8'h00);
        chk("qseq_rd", lr(b), 1);
        chk("qseq_word", w, 32'h40372615);

        @(posedge clk); #1;
        b = lg_dat.size(); c0 = rdy_cnt; cyc = 0;
        mem_addr = 24'h000300; cfg_qspi = 1'b0; mem_valid = 1'b1;
        while (lg_dat.size() < b + 2 && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        chk("abort_in_addr", (lg_dat.size() >= b + 2) ? 1 : 0, 1);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_state", din_valid, 0);
        chk("abort_xfer", xfer_resetn, 0);
        mem_valid = 1'b0; reset = 1'b0;
        repeat (6) @(posedge clk);
        chk("abort_no_ready", rdy_cnt - c0, 0);

        do_read(24'h000100, 1'b0, b, hs, rl, w);
        chk("restart_hs", hs, 8);
        chk("restart_cmd", ld(b), 8'h03);
        chk("restart_word", w, 32'h44332211);

        stall_en = 1'b1;
        do_read(24'hFFFFFC, 1'b0, b, hs, rl, w);
        chk("wrap_hs", hs, 8);
        chk("wrap_a2", ld(b + 1), 8'hFF);
        chk("wrap_a0", ld(b + 3), 8'hFC);
        chk("wrap_word", w, 32'h47302112);

        do_read(24'h000000, 1'b0, b, hs, rl, w);
        chk("wrap_seq_hs", hs, 4);
        chk("wrap_seq_rst", rl, 0);
        chk("wrap_seq_word", w, 32'h44332211);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
